// File: rtl/multi_input_valve_sequencer.sv
// multi_input_valve_sequencer
// Drives the two source-mux valves (cp1/cp2) and the two reagent valves
// (cp3/cp4) of the multi-input cell trap through a fixed source-load then
// reagent-delivery sequence, with all-closed settle time between phases.
// Optional build macro SEQ_ABORT_EN adds an abort input and an aborted flag.
`timescale 1ns/1ps
module multi_input_valve_sequencer #(
  parameter int CNT_W    = 16,
  parameter int DEAD_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_src,
  input  logic [1:0]       cmd_mix_mask,
  input  logic [CNT_W-1:0] cmd_load_cyc,
  input  logic [CNT_W-1:0] cmd_mix_cyc,
`ifdef SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [1:0]       valve_mux,
  output logic [1:0]       valve_mix,
  output logic             busy,
  output logic             done,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE1 = 3'd1,
    S_LOAD    = 3'd2,
    S_SETTLE2 = 3'd3,
    S_MIX     = 3'd4,
    S_SETTLE3 = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] DEAD_M1 = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Latched command fields
  logic             src_q;
  logic [1:0]       mask_q;
  logic [CNT_W-1:0] load_q, mix_q;
  logic             mix_en;

  // Next values of the registered outputs
  logic [1:0]       mux_d, mix_d;
  logic             busy_d, done_d;

`ifdef SEQ_ABORT_EN
  logic             abort_take, abort_q, abort_q_nxt, aborted_d;
`endif

  assign cmd_ready = (state == S_IDLE);
  // MIX is only worth entering if it would open something for a nonzero time
  assign mix_en    = (mix_q != '0) && (mask_q != 2'b00);

  // Capture the command fields on the accepting edge; held until next accept
  always_ff @(posedge clk) begin
    if (cmd_valid && cmd_ready) begin
      src_q  <= cmd_src;
      mask_q <= cmd_mix_mask;
      load_q <= cmd_load_cyc;
      mix_q  <= cmd_mix_cyc;
    end
  end

  // State, phase counter and registered outputs; reset closes valves at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      valve_mux <= 2'b00;
      valve_mix <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      phase     <= 3'd0;
`ifdef SEQ_ABORT_EN
      abort_q   <= 1'b0;
      aborted   <= 1'b0;
`endif
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      valve_mux <= mux_d;
      valve_mix <= mix_d;
      busy      <= busy_d;
      done      <= done_d;
      phase     <= nxt;
`ifdef SEQ_ABORT_EN
      abort_q   <= abort_q_nxt;
      aborted   <= aborted_d;
`endif
    end
  end

  // Phase sequencing with skip rules, plus counter reload on every phase entry
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (cmd_valid) nxt = S_SETTLE1;
      S_SETTLE1: if (cnt == '0) begin
                   if (load_q != '0) nxt = S_LOAD;
                   else if (mix_en)  nxt = S_MIX;
                   else              nxt = S_DONE;
                 end
      S_LOAD:    if (cnt == '0) nxt = S_SETTLE2;
      S_SETTLE2: if (cnt == '0) nxt = mix_en ? S_MIX : S_DONE;
      S_MIX:     if (cnt == '0) nxt = S_SETTLE3;
      S_SETTLE3: if (cnt == '0) nxt = S_DONE;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
`ifdef SEQ_ABORT_EN
    abort_take = 1'b0;
    // An abort still honours the full dead time before DONE
    if (abort && (state == S_SETTLE1 || state == S_LOAD ||
                  state == S_SETTLE2 || state == S_MIX)) begin
      nxt        = S_SETTLE3;
      abort_take = 1'b1;
    end
    abort_q_nxt = (state == S_IDLE) ? 1'b0 : (abort_q | abort_take);
`endif
    cnt_nxt = cnt;
    if (nxt != state) begin
      // Durations are loaded as N-1 so the maximum field value never wraps
      case (nxt)
        S_SETTLE1, S_SETTLE2, S_SETTLE3: cnt_nxt = DEAD_M1;
        S_LOAD:                          cnt_nxt = load_q - ONE;
        S_MIX:                           cnt_nxt = mix_q - ONE;
        default:                         cnt_nxt = '0;
      endcase
    end else if (cnt != '0) begin
      cnt_nxt = cnt - ONE;
    end
  end

  // Output decode from the next state so valves change with the phase edge
  always_comb begin
    mux_d  = 2'b00;
    mix_d  = 2'b00;
    busy_d = (nxt != S_IDLE);
    done_d = (nxt == S_DONE);
    if (nxt == S_LOAD) mux_d = src_q ? 2'b10 : 2'b01;
    if (nxt == S_MIX)  mix_d = mask_q;
`ifdef SEQ_ABORT_EN
    aborted_d = (nxt == S_DONE) && abort_q;
`endif
  end

endmodule
